operand_mux_pipe: RTL
=====================

# operand_mux_pipe

Parametrised N-input operand selector with a registered, flow-controlled output stage. It succeeds the fixed 4:1 combinational selector used between the register file, ALU and memory paths. It is generalised in channel count and width, and it adds a two-entry elastic buffer with valid/ready handshake and flush. It sits at the operand/write-back select points of the multi-cycle and pipelined CPU variants, where the selected value must be held across stalls.

## Interface
Parameters:
- DATA_WIDTH, 16, width of each input channel and of dout
- NUM_IN, 4, number of input channels; legal range 2..16
- SEL_WIDTH, 2, select width; must satisfy 2**SEL_WIDTH >= NUM_IN

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  upstream offers sel/din this cycle
- in_ready  out  1  block can accept this cycle
- sel  in  SEL_WIDTH  channel index, sampled on accept
- din  in  NUM_IN*DATA_WIDTH  flattened channels; channel k is din[k*DATA_WIDTH +: DATA_WIDTH]
- flush  in  1  synchronous discard of all buffered entries
- out_valid  out  1  dout/out_sel hold a valid entry
- out_ready  in  1  downstream consumes this cycle
- dout  out  DATA_WIDTH  selected data of the head entry
- out_sel  out  SEL_WIDTH  select value that produced dout
- sel_err  out  1  sticky out-of-range flag; present only with OPMUX_SEL_CHECK_EN

## Operation
- Accept occurs when in_valid && in_ready. Selection happens at accept time: the entry stores {sel, din[sel]}.
- Out-of-range sel (sel >= NUM_IN) stores channel 0 data with the original sel value.
- Pop occurs when out_valid && out_ready.
- Two-entry FIFO, order preserved. States are EMPTY, ONE and FULL.
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; accept and pop together -> ONE.
  - FULL: pop -> ONE. No accept is possible because in_ready=0.
- in_ready = (state != FULL). It is a function of the state register only and never depends combinationally on out_ready.
- out_valid = (state != EMPTY). dout and out_sel come from the head register.
- flush forces EMPTY next cycle and overrides a simultaneous accept or pop. Data registers keep their stale values; only the state changes.
- Asserting rst at any time, mid-transfer included, immediately gives state=EMPTY, dout=0, out_sel=0, sel_err=0, out_valid=0, in_ready=1.

## Timing
- Latency is 1 cycle: an entry accepted at edge N is visible on dout with out_valid=1 after edge N.
- Throughput is 1 entry/cycle while out_ready stays high.
- dout/out_sel stay stable while out_valid=1 and out_ready=0.
- A stall of one cycle fills the skid entry. in_ready drops the cycle after the FULL transition, not combinationally.
- When out_ready rises in FULL, in_ready returns high the next cycle.

## Configuration
- OPMUX_SEL_CHECK_EN defined:
  - sel_err port exists.
  - It is set on any accept with sel >= NUM_IN and stays set until rst. flush does not clear it.
  - Entry data is still channel 0.
- OPMUX_SEL_CHECK_EN undefined: no sel_err port and no check logic. Out-of-range selects silently yield channel 0.

## Structure
- Shared package opmux_pkg:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2
  - a localparam check helper asserting 2**SEL_WIDTH >= NUM_IN
- One sub-module, opmux_sel: purely combinational NUM_IN:1 selector with the channel-0 default. It is instantiated once at the input side.
- The top holds the state register, head and skid registers, and the flag.

## Test plan
- NUM_IN=4, DATA_WIDTH=16, out_ready=1, inputs ch0..ch3 = 0x1111, 0x2222, 0x3333, 0x4444, in_valid=1 with sel=2 at edge 0 -> dout=0x3333, out_sel=2, out_valid=1 after edge 0; back-to-back sel 0,1,3 give 0x1111, 0x2222, 0x4444 on consecutive cycles.
- Hold out_ready=0 and push three entries (sel 1, 2, 3) -> only the first two accepted; in_ready=0 from the cycle after the second accept; dout stays 0x2222. Release out_ready -> 0x2222 then 0x3333, with no loss or reordering.
- In FULL, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered entry is dropped.
- NUM_IN=3, SEL_WIDTH=2, sel=3 -> dout=channel 0 value, out_sel=3. With OPMUX_SEL_CHECK_EN, sel_err=1 stays set after later flushes and valid selects.
- Assert rst asynchronously mid-cycle while FULL -> outputs immediately return to out_valid=0, dout=0, out_sel=0, in_ready=1. Normal operation resumes on the first edge after release.
- NUM_IN=16, DATA_WIDTH=32 random traffic with random out_ready, checked against a reference queue model -> zero mismatches over 10,000 cycles.

Source files
------------

// File: rtl/operand_mux_pipe_pkg.sv
// Shared definitions for operand_mux_pipe: FSM state constants and a
// parameter sanity helper.
package opmux_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  // True when the channel count is legal and the select field can address every channel.
  function automatic bit sel_width_ok(input int unsigned sel_width, input int unsigned num_in);
    return (num_in >= 2) && (num_in <= 16) && ((32'd1 << sel_width) >= num_in);
  endfunction

endpackage

// File: rtl/operand_mux_pipe_if.sv
// Handshake/data bundle for operand_mux_pipe. sel_err exists only when
// OPMUX_SEL_CHECK_EN is defined.
interface operand_mux_pipe_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = 2
);
  logic                         in_valid;
  logic                         in_ready;
  logic [SEL_WIDTH-1:0]         sel;
  logic [NUM_IN*DATA_WIDTH-1:0] din;
  logic                         flush;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH-1:0]        dout;
  logic [SEL_WIDTH-1:0]         out_sel;
`ifdef OPMUX_SEL_CHECK_EN
  logic                         sel_err;
`endif

  // Upstream/downstream agent side.
  modport master (
    output in_valid, sel, din, flush, out_ready,
    input  in_ready, out_valid, dout, out_sel
`ifdef OPMUX_SEL_CHECK_EN
    , input sel_err
`endif
  );

  // operand_mux_pipe side.
  modport slave (
    input  in_valid, sel, din, flush, out_ready,
    output in_ready, out_valid, dout, out_sel
`ifdef OPMUX_SEL_CHECK_EN
    , output sel_err
`endif
  );
endinterface

// File: rtl/operand_mux_pipe_sel.sv
// Combinational NUM_IN:1 channel selector; out-of-range selects yield channel 0.
module opmux_sel #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic [SEL_WIDTH-1:0]         sel_i,
  input  logic [NUM_IN*DATA_WIDTH-1:0] din_i,
  output logic [DATA_WIDTH-1:0]        dout_o
);

  // Channel 0 is the default; any matching in-range index overrides it.
  always_comb begin
    dout_o = din_i[DATA_WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (32'(sel_i) == k) dout_o = din_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

endmodule

// File: rtl/operand_mux_pipe.sv
// operand_mux_pipe: N-input operand selector feeding a two-entry elastic
// buffer (head + skid) with valid/ready handshake and synchronous flush.
// Optional sticky out-of-range flag under OPMUX_SEL_CHECK_EN.
module operand_mux_pipe
  import opmux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_IN     = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input logic               clk,
  input logic               rst,
  operand_mux_pipe_if.slave bus
);

  localparam int unsigned EW = SEL_WIDTH + DATA_WIDTH;

  if (!sel_width_ok(SEL_WIDTH, NUM_IN)) begin : g_param_err
    $error("operand_mux_pipe: illegal NUM_IN/SEL_WIDTH combination");
  end

  logic [1:0]            state_q, state_d;
  logic [EW-1:0]         head_q, head_d;
  logic [EW-1:0]         skid_q, skid_d;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [EW-1:0]         new_entry;
  logic                  accept;
  logic                  pop;

  opmux_sel #(
    .DATA_WIDTH(DATA_WIDTH),
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_sel (
    .sel_i (bus.sel),
    .din_i (bus.din),
    .dout_o(sel_data)
  );

  assign new_entry     = {bus.sel, sel_data};
  assign bus.in_ready  = (state_q != ST_FULL);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.dout      = head_q[DATA_WIDTH-1:0];
  assign bus.out_sel   = head_q[EW-1:DATA_WIDTH];
  assign accept        = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Next-state and data-register update; flush wins over accept/pop and leaves data stale.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: if (accept) begin
        head_d  = new_entry;
        state_d = ST_ONE;
      end
      ST_ONE: begin
        if (accept && pop) begin
          head_d = new_entry;
        end else if (accept) begin
          skid_d  = new_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: if (pop) begin
        head_d  = skid_q;
        state_d = ST_ONE;
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d = ST_EMPTY;
      head_d  = head_q;
      skid_d  = skid_q;
    end
  end

  // State and entry registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

`ifdef OPMUX_SEL_CHECK_EN
  logic sel_err_q;
  logic sel_oor;

  assign sel_oor     = (32'(bus.sel) >= NUM_IN);
  assign bus.sel_err = sel_err_q;

  // Sticky out-of-range flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_q <= 1'b0;
    end else if (accept && !bus.flush && sel_oor) begin
      sel_err_q <= 1'b1;
    end
  end
`endif

endmodule
